// File: rtl/registro_burst_pkg.sv
// Shared definitions for the registro_burst universal shift register:
// operation codes, burst FSM states and a shift-op classifier.
package registro_burst_pkg;

  typedef enum logic [2:0] {
    RB_HOLD  = 3'd0,
    RB_LOAD  = 3'd1,
    RB_PUSH  = 3'd2,
    RB_CYCLE = 3'd3,
    RB_ARITH = 3'd4
  } rb_op_e;

  typedef enum logic [1:0] {
    RB_IDLE  = 2'd0,
    RB_SHIFT = 2'd1,
    RB_FIN   = 2'd2
  } rb_state_e;

  // Only these codes move bits and update S_OUT; undefined codes behave as HOLD.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == RB_PUSH) || (op == RB_CYCLE) || (op == RB_ARITH);
  endfunction

endpackage

// File: rtl/registro_burst_if.sv
// Control/data bundle of registro_burst; the master drives operations, the
// slave (the register) returns contents, burst status and FSM state.
interface registro_burst_if
  import registro_burst_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CNT_W = 6
);
  // Burst handshake: START is sampled only in IDLE on an ENB-high edge; BUSY
  // stays high while latched shifts remain; DONE pulses for one cycle at the
  // end, and the next START is accepted no sooner than two cycles later.
  logic             ENB;
  logic [2:0]       MODO;
  logic             DIR;
  logic [STEP-1:0]  S_IN;
  logic [WIDTH-1:0] D;
  logic             START;
  logic [CNT_W-1:0] N;
  logic [WIDTH-1:0] Q;
  logic [STEP-1:0]  S_OUT;
  logic             BUSY;
  logic             DONE;
  rb_state_e        STATE;

  modport master (
    output ENB, MODO, DIR, S_IN, D, START, N,
    input  Q, S_OUT, BUSY, DONE, STATE
  );

  modport slave (
    input  ENB, MODO, DIR, S_IN, D, START, N,
    output Q, S_OUT, BUSY, DONE, STATE
  );
endinterface

// File: rtl/registro_burst_core.sv
// Combinational next-Q / next-S_OUT function for one step of the shift
// register; the caller decides when the result is committed.
module registro_burst_core
  import registro_burst_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       op_i,
  input  logic             dir_i,
  input  logic [STEP-1:0]  s_in_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [STEP-1:0]  s_out_o,
  output logic             s_out_upd_o
);

  logic [STEP-1:0] fill;
  logic [STEP-1:0] exit_bits;

  // Bits leaving Q: top slice on a left shift, bottom slice on a right shift.
  assign exit_bits = dir_i ? q_i[STEP-1:0] : q_i[WIDTH-1 -: STEP];

  always_comb begin
    fill = '0;
    case (op_i)
      RB_PUSH:  fill = s_in_i;
      RB_CYCLE: fill = exit_bits;
      RB_ARITH: fill = dir_i ? {STEP{q_i[WIDTH-1]}} : '0;
      default:  fill = '0;
    endcase
  end

  always_comb begin
    q_o         = q_i;
    s_out_upd_o = 1'b0;
    if (op_i == RB_LOAD) begin
      q_o = d_i;
    end else if (is_shift_op(op_i)) begin
      s_out_upd_o = 1'b1;
      q_o = dir_i ? {fill, q_i[WIDTH-1:STEP]} : {q_i[WIDTH-1-STEP:0], fill};
    end
  end

  assign s_out_o = exit_bits;

endmodule

// File: rtl/registro_burst.sv
// Parametrised universal shift register with free-running ops and a counted
// burst mode (START/BUSY/DONE); holds the Q/S_OUT flops, FSM and counter.
module registro_burst
  import registro_burst_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CNT_W = 6
) (
  input logic            CLK,
  input logic            RESET_L,
  registro_burst_if.slave bus
);

  rb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [STEP-1:0]  s_out_q, s_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       core_op;
  logic             core_dir;
  logic [WIDTH-1:0] core_q;
  logic [STEP-1:0]  core_s_out;
  logic             core_upd;

  registro_burst_core #(.WIDTH(WIDTH), .STEP(STEP)) u_core (
    .q_i         (q_q),
    .op_i        (core_op),
    .dir_i       (core_dir),
    .s_in_i      (bus.S_IN),
    .d_i         (bus.D),
    .q_o         (core_q),
    .s_out_o     (core_s_out),
    .s_out_upd_o (core_upd)
  );

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= RB_IDLE;
      cnt_q   <= '0;
      op_q    <= RB_HOLD;
      dir_q   <= 1'b0;
      q_q     <= '0;
      s_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dir_q   <= dir_d;
      q_q     <= q_d;
      s_out_q <= s_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dir_d    = dir_q;
    q_d      = q_q;
    s_out_d  = s_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    core_op  = bus.MODO;
    core_dir = bus.DIR;
    case (state_q)
      RB_IDLE: begin
        if (bus.ENB) begin
          if (bus.START) begin
            op_d  = bus.MODO;
            dir_d = bus.DIR;
            cnt_d = bus.N;
            // A latched LOAD is the only burst that touches Q on the START edge.
            if (bus.MODO == RB_LOAD) q_d = bus.D;
            if (is_shift_op(bus.MODO) && (bus.N != '0)) begin
              state_d = RB_SHIFT;
              busy_d  = 1'b1;
            end else begin
              state_d = RB_FIN;
              done_d  = 1'b1;
              cnt_d   = '0;
            end
          end else begin
            q_d = core_q;
            if (core_upd) s_out_d = core_s_out;
          end
        end
      end
      RB_SHIFT: begin
        core_op  = op_q;
        core_dir = dir_q;
        if (bus.ENB) begin
          q_d     = core_q;
          s_out_d = core_s_out;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = RB_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      RB_FIN:  state_d = RB_IDLE;
      default: state_d = RB_IDLE;
    endcase
  end

  assign bus.Q     = q_q;
  assign bus.S_OUT = s_out_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.STATE = state_q;

endmodule
